// File: rtl/udma_filter_pkg.sv
// Shared encodings, FSM state type and helpers for the filter stream source.
package udma_filter_pkg;

  localparam logic [1:0] DS_BYTE = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_WORD = 2'b10;

  localparam logic SRC_LINEAR = 1'b0;
  localparam logic SRC_2D     = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } src_state_e;

  // Element size in bytes; the reserved encoding 11 behaves as a word.
  function automatic logic [2:0] bytes_per_elem(input logic [1:0] ds);
    case (ds)
      DS_BYTE: return 3'd1;
      DS_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/udma_filter_src_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop may coincide.
module udma_filter_src_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Storage array; contents need no reset since count gates validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/udma_filter_stream_src.sv
// L2 read stream source feeding one operand port of the filter datapath.
//
// state | meaning
// IDLE  | waiting for cmd_start_i
// REQ   | issuing read requests, credit limited
// DRAIN | all requests granted, emptying returned elements
module udma_filter_stream_src #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int TRANS_SIZE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_start_i,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_mode_i,
  input  logic [TRANS_SIZE-1:0] cfg_len0_i,
  input  logic [TRANS_SIZE-1:0] cfg_len1_i,
  input  logic [TRANS_SIZE-1:0] cfg_stride_i,
  output logic                  status_busy_o,
  output logic                  event_done_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic [DATA_WIDTH-1:0] stream_data_o,
  output logic [1:0]            stream_datasize_o,
  output logic                  stream_valid_o,
  output logic                  stream_sof_o,
  output logic                  stream_eof_o,
  input  logic                  stream_ready_i
);

  import udma_filter_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  src_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] row_addr_q, elem_addr_q;
  logic [1:0]            ds_q;
  logic [TRANS_SIZE-1:0] len0_q, len1_q, stride_q;
  logic [TRANS_SIZE-1:0] col_q, row_q, rsp_col_q, out_row_q;
  logic                  done_q;

  logic [CW-1:0]         tag_count, dat_count;
  logic [1:0]            tag_off;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH+1:0] dat_in, dat_out;

  logic start_ok, cfg_empty, credit_ok, gnt_ok, rsp_ok, pop, last_pop;
  logic last_col, last_row, rsp_last_col;

  assign start_ok  = (state_q == IDLE) && cmd_start_i;
  assign cfg_empty = (cfg_len0_i == '0) || ((cfg_mode_i == SRC_2D) && (cfg_len1_i == '0));

  // Requests in flight (tag queue) plus buffered elements never exceed the
  // data FIFO depth, so every response finds a free slot.
  assign credit_ok = ({1'b0, tag_count} + {1'b0, dat_count}) < (CW+1)'(FIFO_DEPTH);

  assign mem_req_o  = (state_q == REQ) && credit_ok;
  assign mem_addr_o = {elem_addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign gnt_ok     = mem_req_o && mem_gnt_i;

  assign last_col     = (col_q == len0_q - TRANS_SIZE'(1));
  assign last_row     = (row_q == len1_q - TRANS_SIZE'(1));
  assign rsp_last_col = (rsp_col_q == len0_q - TRANS_SIZE'(1));

  // Responses with nothing outstanding are leftovers from an aborted run.
  assign rsp_ok = mem_rvalid_i && (tag_count != '0);

  assign stream_valid_o = (dat_count != '0);
  assign pop            = stream_valid_o && stream_ready_i;
  assign last_pop       = pop && (state_q == DRAIN) && dat_out[0] &&
                          (out_row_q == len1_q - TRANS_SIZE'(1));

  assign stream_data_o     = stream_valid_o ? dat_out[DATA_WIDTH+1:2] : '0;
  assign stream_sof_o      = stream_valid_o && dat_out[1];
  assign stream_eof_o      = stream_valid_o && dat_out[0];
  assign stream_datasize_o = ds_q;
  assign status_busy_o     = (state_q != IDLE);
  assign event_done_o      = done_q;

  // Extract the element lane from the returned word using the queued offset.
  always_comb begin
    lane = '0;
    case (ds_q)
      DS_BYTE: lane[7:0]  = mem_rdata_i[8*tag_off +: 8];
      DS_HALF: lane[15:0] = tag_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      default: lane[31:0] = mem_rdata_i;
    endcase
  end

  assign dat_in = {lane, (rsp_col_q == '0), rsp_last_col};

  udma_filter_src_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt_ok),
    .data_i  (elem_addr_q[1:0]),
    .pop_i   (rsp_ok),
    .data_o  (tag_off),
    .count_o (tag_count)
  );

  udma_filter_src_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_ok),
    .data_i  (dat_in),
    .pop_i   (pop),
    .data_o  (dat_out),
    .count_o (dat_count)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok && !cfg_empty) state_d = REQ;
      REQ:     if (gnt_ok && last_col && last_row) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config latch, incremental address generation and element position tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ds_q        <= '0;
      len0_q      <= '0;
      len1_q      <= '0;
      stride_q    <= '0;
      row_addr_q  <= '0;
      elem_addr_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rsp_col_q   <= '0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (start_ok && cfg_empty) || last_pop;
      if (start_ok) begin
        ds_q        <= cfg_datasize_i;
        len0_q      <= cfg_len0_i;
        len1_q      <= (cfg_mode_i == SRC_2D) ? cfg_len1_i : TRANS_SIZE'(1);
        stride_q    <= cfg_stride_i;
        row_addr_q  <= cfg_start_addr_i;
        elem_addr_q <= cfg_start_addr_i;
        col_q       <= '0;
        row_q       <= '0;
        rsp_col_q   <= '0;
        out_row_q   <= '0;
      end else begin
        if (gnt_ok) begin
          if (last_col) begin
            col_q       <= '0;
            row_q       <= row_q + TRANS_SIZE'(1);
            row_addr_q  <= row_addr_q + ADDR_WIDTH'(stride_q);
            elem_addr_q <= row_addr_q + ADDR_WIDTH'(stride_q);
          end else begin
            col_q       <= col_q + TRANS_SIZE'(1);
            elem_addr_q <= elem_addr_q + ADDR_WIDTH'(bytes_per_elem(ds_q));
          end
        end
        if (rsp_ok) rsp_col_q <= rsp_last_col ? '0 : rsp_col_q + TRANS_SIZE'(1);
        if (pop && dat_out[0]) out_row_q <= out_row_q + TRANS_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_udma_filter_stream_src.sv
// Directed bench for udma_filter_stream_src with an L2 responder model.
module tb_udma_filter_stream_src;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int TS = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          cmd_start_i = 1'b0;
  logic [AW-1:0] cfg_start_addr_i = '0;
  logic [1:0]    cfg_datasize_i = '0;
  logic          cfg_mode_i = 1'b0;
  logic [TS-1:0] cfg_len0_i = '0, cfg_len1_i = '0, cfg_stride_i = '0;
  logic          status_busy_o, event_done_o, mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;
  logic [DW-1:0] stream_data_o;
  logic [1:0]    stream_datasize_o;
  logic          stream_valid_o, stream_sof_o, stream_eof_o;
  logic          stream_ready_i = 1'b0;

  udma_filter_stream_src #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .TRANS_SIZE (TS), .FIFO_DEPTH (FD)
  ) dut (
    .clk_i (clk), .rst_i (rst_i), .cmd_start_i (cmd_start_i),
    .cfg_start_addr_i (cfg_start_addr_i), .cfg_datasize_i (cfg_datasize_i),
    .cfg_mode_i (cfg_mode_i), .cfg_len0_i (cfg_len0_i), .cfg_len1_i (cfg_len1_i),
    .cfg_stride_i (cfg_stride_i), .status_busy_o (status_busy_o),
    .event_done_o (event_done_o), .mem_req_o (mem_req_o), .mem_addr_o (mem_addr_o),
    .mem_gnt_i (mem_gnt_i), .mem_rvalid_i (mem_rvalid_i), .mem_rdata_i (mem_rdata_i),
    .stream_data_o (stream_data_o), .stream_datasize_o (stream_datasize_o),
    .stream_valid_o (stream_valid_o), .stream_sof_o (stream_sof_o),
    .stream_eof_o (stream_eof_o), .stream_ready_i (stream_ready_i)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] mem [256];

  int gnt_delay = 0, lat_max = 0, rdy_mode = 0, gnt_wait = 0;
  logic [AW-1:0] pend_addr [$];
  int            pend_due  [$];
  logic [AW-1:0] req_log   [$];
  logic [31:0]   cap_data  [$];
  logic          cap_sof   [$];
  logic          cap_eof   [$];
  int first_req_cyc = -1, hs_last_cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
  int addr_err = 0, stab_err = 0;
  logic busy_at_done = 1'b0, busy_seen = 1'b0, valid_seen = 1'b0;
  logic prev_wait = 1'b0, prev_stall = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0;

  // L2 responder, consumer and observer, all acting on the falling edge.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem[a[9:2]];
    end
    if (prev_wait && (!mem_req_o || mem_addr_o !== prev_addr)) addr_err++;
    prev_wait = 1'b0;
    mem_gnt_i = 1'b0;
    if (mem_req_o) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (gnt_wait >= gnt_delay) begin
        mem_gnt_i = 1'b1;
        gnt_wait  = 0;
        req_log.push_back(mem_addr_o);
        pend_addr.push_back(mem_addr_o);
        pend_due.push_back(cyc + 1 + int'($urandom_range(lat_max, 0)));
      end else begin
        gnt_wait++;
        prev_wait = 1'b1;
        prev_addr = mem_addr_o;
      end
    end
    case (rdy_mode)
      0:       stream_ready_i = 1'b1;
      1:       stream_ready_i = 1'b0;
      default: stream_ready_i = 1'($urandom_range(1, 0));
    endcase
    if (prev_stall && (!stream_valid_o || stream_data_o !== prev_data ||
                       stream_sof_o !== prev_sof || stream_eof_o !== prev_eof)) stab_err++;
    prev_stall = stream_valid_o && !stream_ready_i;
    prev_data  = stream_data_o;
    prev_sof   = stream_sof_o;
    prev_eof   = stream_eof_o;
    if (stream_valid_o) valid_seen = 1'b1;
    if (status_busy_o)  busy_seen  = 1'b1;
    if (stream_valid_o && stream_ready_i) begin
      cap_data.push_back(stream_data_o);
      cap_sof.push_back(stream_sof_o);
      cap_eof.push_back(stream_eof_o);
      hs_last_cyc = cyc;
    end
    if (event_done_o) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = status_busy_o;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete(); cap_data.delete(); cap_sof.delete(); cap_eof.delete();
    first_req_cyc = -1; done_cnt = 0; addr_err = 0; stab_err = 0;
    busy_seen = 1'b0; valid_seen = 1'b0;
  endtask

  task automatic start_xfer(input logic [AW-1:0] addr, input logic [1:0] ds, input logic mode,
                            input logic [TS-1:0] l0, input logic [TS-1:0] l1, input logic [TS-1:0] st);
    tick();
    cfg_start_addr_i = addr; cfg_datasize_i = ds; cfg_mode_i = mode;
    cfg_len0_i = l0; cfg_len1_i = l1; cfg_stride_i = st;
    cmd_start_i = 1'b1;
    start_cyc = cyc + 1;
    tick();
    cmd_start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt < 1 && n < limit) begin
      tick();
      n++;
    end
    repeat (4) tick();
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL done_count: got %0d expected 1 (limit %0d cycles)", done_cnt, limit);
    end
  endtask

  function automatic logic [15:0] sof_bits();
    logic [15:0] r = '0;
    for (int i = 0; i < cap_sof.size() && i < 16; i++) r[i] = cap_sof[i];
    return r;
  endfunction

  function automatic logic [15:0] eof_bits();
    logic [15:0] r = '0;
    for (int i = 0; i < cap_eof.size() && i < 16; i++) r[i] = cap_eof[i];
    return r;
  endfunction

  task automatic test_reset();
    repeat (3) tick();
    tests++;
    if ({status_busy_o, event_done_o, mem_req_o, mem_addr_o, stream_data_o, stream_datasize_o,
         stream_valid_o, stream_sof_o, stream_eof_o} !== 58'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b done=%b req=%b addr=%0h data=%0h ds=%0d v=%b sof=%b eof=%b expected all 0",
               status_busy_o, event_done_o, mem_req_o, mem_addr_o, stream_data_o,
               stream_datasize_o, stream_valid_o, stream_sof_o, stream_eof_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_linear_byte();
    logic [31:0] ed [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    gnt_delay = 0; lat_max = 0; rdy_mode = 0;
    mem[8'h40] = 32'h44332211;
    clear_logs();
    start_xfer(18'h100, 2'b00, 1'b0, 16'd4, 16'd0, 16'd0);
    wait_done(100);
    tests++;
    if (first_req_cyc != start_cyc) begin
      fails++; $display("FAIL lin_first_req_cycle: got %0d expected %0d", first_req_cyc, start_cyc);
    end
    tests++;
    if (req_log.size() != 4) begin
      fails++; $display("FAIL lin_req_count: got %0d expected 4", req_log.size());
    end
    for (int i = 0; i < req_log.size(); i++) begin
      tests++;
      if (req_log[i] !== 18'h100) begin
        fails++; $display("FAIL lin_addr[%0d]: got %0h expected 100", i, req_log[i]);
      end
    end
    tests++;
    if (cap_data.size() != 4) begin
      fails++; $display("FAIL lin_elem_count: got %0d expected 4", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 4; i++) begin
      tests++;
      if (cap_data[i] !== ed[i]) begin
        fails++; $display("FAIL lin_data[%0d]: got %0h expected %0h", i, cap_data[i], ed[i]);
      end
    end
    tests++;
    if (sof_bits() !== 16'h0001 || eof_bits() !== 16'h0008) begin
      fails++; $display("FAIL lin_sof_eof: got sof=%0h eof=%0h expected sof=1 eof=8", sof_bits(), eof_bits());
    end
    tests++;
    if (done_cyc != hs_last_cyc + 1 || busy_at_done !== 1'b0) begin
      fails++; $display("FAIL lin_done_timing: got cyc=%0d busy=%b expected cyc=%0d busy=0",
                        done_cyc, busy_at_done, hs_last_cyc + 1);
    end
  endtask

  task automatic test_half();
    logic [31:0] ed [3] = '{32'hBBBB, 32'hCCCC, 32'hDDDD};
    logic [AW-1:0] ea [3] = '{18'h100, 18'h104, 18'h104};
    gnt_delay = 0; lat_max = 2; rdy_mode = 0;
    mem[8'h40] = 32'hBBBBAAAA;
    mem[8'h41] = 32'hDDDDCCCC;
    clear_logs();
    start_xfer(18'h102, 2'b01, 1'b0, 16'd3, 16'd0, 16'd0);
    wait_done(100);
    tests++;
    if (req_log.size() != 3 || cap_data.size() != 3) begin
      fails++; $display("FAIL half_counts: got req=%0d elem=%0d expected 3/3", req_log.size(), cap_data.size());
    end
    for (int i = 0; i < req_log.size() && i < 3; i++) begin
      tests++;
      if (req_log[i] !== ea[i]) begin
        fails++; $display("FAIL half_addr[%0d]: got %0h expected %0h", i, req_log[i], ea[i]);
      end
    end
    for (int i = 0; i < cap_data.size() && i < 3; i++) begin
      tests++;
      if (cap_data[i] !== ed[i]) begin
        fails++; $display("FAIL half_data[%0d]: got %0h expected %0h", i, cap_data[i], ed[i]);
      end
    end
    tests++;
    if (sof_bits() !== 16'h0001 || eof_bits() !== 16'h0004) begin
      fails++; $display("FAIL half_sof_eof: got sof=%0h eof=%0h expected sof=1 eof=4", sof_bits(), eof_bits());
    end
  endtask

  task automatic test_2d_word();
    logic [31:0] ed [4] = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978};
    logic [AW-1:0] ea [4] = '{18'h200, 18'h204, 18'h210, 18'h214};
    gnt_delay = 0; lat_max = 1; rdy_mode = 0;
    mem[8'h80] = ed[0]; mem[8'h81] = ed[1]; mem[8'h84] = ed[2]; mem[8'h85] = ed[3];
    clear_logs();
    start_xfer(18'h200, 2'b10, 1'b1, 16'd2, 16'd2, 16'h10);
    cfg_start_addr_i = 18'h3000; cfg_datasize_i = 2'b00; cfg_len0_i = 16'd7; cfg_stride_i = 16'h40;
    wait_done(100);
    tests++;
    if (req_log.size() != 4 || cap_data.size() != 4) begin
      fails++; $display("FAIL 2d_counts: got req=%0d elem=%0d expected 4/4", req_log.size(), cap_data.size());
    end
    for (int i = 0; i < req_log.size() && i < 4; i++) begin
      tests++;
      if (req_log[i] !== ea[i]) begin
        fails++; $display("FAIL 2d_addr[%0d]: got %0h expected %0h", i, req_log[i], ea[i]);
      end
    end
    for (int i = 0; i < cap_data.size() && i < 4; i++) begin
      tests++;
      if (cap_data[i] !== ed[i]) begin
        fails++; $display("FAIL 2d_data[%0d]: got %0h expected %0h", i, cap_data[i], ed[i]);
      end
    end
    tests++;
    if (sof_bits() !== 16'h0005 || eof_bits() !== 16'h000A) begin
      fails++; $display("FAIL 2d_sof_eof: got sof=%0h eof=%0h expected sof=5 eof=a", sof_bits(), eof_bits());
    end
    tests++;
    if (stream_datasize_o !== 2'b10) begin
      fails++; $display("FAIL 2d_datasize: got %0d expected 2", stream_datasize_o);
    end
  endtask

  task automatic test_backpressure();
    gnt_delay = 0; lat_max = 0; rdy_mode = 1;
    clear_logs();
    start_xfer(18'h000, 2'b10, 1'b0, 16'd16, 16'd0, 16'd0);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 10) begin
        cfg_len0_i = 16'd3; cfg_start_addr_i = 18'h80; cmd_start_i = 1'b1;
      end
      if (i == 11) cmd_start_i = 1'b0;
    end
    tests++;
    if (req_log.size() != FD || mem_req_o !== 1'b0 || stream_valid_o !== 1'b1) begin
      fails++; $display("FAIL bp_credit: got grants=%0d req=%b valid=%b expected %0d/0/1",
                        req_log.size(), mem_req_o, stream_valid_o, FD);
    end
    rdy_mode = 0;
    wait_done(300);
    tests++;
    if (cap_data.size() != 16) begin
      fails++; $display("FAIL bp_elem_count: got %0d expected 16", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 16; i++) begin
      tests++;
      if (cap_data[i] !== 32'hC0DE0000 + 32'(i)) begin
        fails++; $display("FAIL bp_data[%0d]: got %0h expected %0h", i, cap_data[i], 32'hC0DE0000 + 32'(i));
      end
    end
    tests++;
    if (sof_bits() !== 16'h0001 || eof_bits() !== 16'h8000 || stab_err != 0) begin
      fails++; $display("FAIL bp_flags_stable: got sof=%0h eof=%0h stab_err=%0d expected 1/8000/0",
                        sof_bits(), eof_bits(), stab_err);
    end
  endtask

  task automatic test_gnt_wait();
    logic [31:0] ed [6] = '{32'h43, 32'h65, 32'h87, 32'h98, 32'hBA, 32'hDC};
    logic [AW-1:0] ea [6] = '{18'h40, 18'h40, 18'h40, 18'h44, 18'h44, 18'h44};
    gnt_delay = 3; lat_max = 3; rdy_mode = 2;
    mem[8'h10] = 32'h87654321;
    mem[8'h11] = 32'hFEDCBA98;
    clear_logs();
    start_xfer(18'h041, 2'b00, 1'b0, 16'd6, 16'd0, 16'd0);
    wait_done(400);
    tests++;
    if (req_log.size() != 6 || cap_data.size() != 6 || addr_err != 0 || stab_err != 0) begin
      fails++; $display("FAIL gw_counts: got req=%0d elem=%0d addr_err=%0d stab_err=%0d expected 6/6/0/0",
                        req_log.size(), cap_data.size(), addr_err, stab_err);
    end
    for (int i = 0; i < req_log.size() && i < 6; i++) begin
      tests++;
      if (req_log[i] !== ea[i]) begin
        fails++; $display("FAIL gw_addr[%0d]: got %0h expected %0h", i, req_log[i], ea[i]);
      end
    end
    for (int i = 0; i < cap_data.size() && i < 6; i++) begin
      tests++;
      if (cap_data[i] !== ed[i]) begin
        fails++; $display("FAIL gw_data[%0d]: got %0h expected %0h", i, cap_data[i], ed[i]);
      end
    end
    gnt_delay = 0; lat_max = 0; rdy_mode = 0;
  endtask

  task automatic test_empty();
    clear_logs();
    start_xfer(18'h100, 2'b10, 1'b0, 16'd0, 16'd5, 16'd0);
    wait_done(20);
    tests++;
    if (done_cyc != start_cyc || req_log.size() != 0 || busy_seen !== 1'b0) begin
      fails++; $display("FAIL empty_lin: got done_cyc=%0d reqs=%0d busy_seen=%b expected %0d/0/0",
                        done_cyc, req_log.size(), busy_seen, start_cyc);
    end
    clear_logs();
    start_xfer(18'h100, 2'b10, 1'b1, 16'd3, 16'd0, 16'd4);
    wait_done(20);
    tests++;
    if (done_cyc != start_cyc || req_log.size() != 0 || busy_seen !== 1'b0) begin
      fails++; $display("FAIL empty_2d: got done_cyc=%0d reqs=%0d busy_seen=%b expected %0d/0/0",
                        done_cyc, req_log.size(), busy_seen, start_cyc);
    end
    clear_logs();
    start_xfer(18'h100, 2'b10, 1'b0, 16'd2, 16'd0, 16'd0);
    wait_done(100);
    tests++;
    if (cap_data.size() != 2 || cap_data[0] !== 32'hBBBBAAAA || cap_data[1] !== 32'hDDDDCCCC) begin
      fails++; $display("FAIL lin_len1_zero: got n=%0d expected 2 words bbbbaaaa,ddddcccc", cap_data.size());
    end
  endtask

  task automatic test_mid_reset();
    gnt_delay = 0; lat_max = 2; rdy_mode = 0;
    clear_logs();
    start_xfer(18'h000, 2'b10, 1'b0, 16'd12, 16'd0, 16'd0);
    repeat (4) tick();
    rst_i = 1'b1;
    tick();
    tests++;
    if ({status_busy_o, event_done_o, mem_req_o, mem_addr_o, stream_data_o, stream_datasize_o,
         stream_valid_o, stream_sof_o, stream_eof_o} !== 58'd0) begin
      fails++;
      $display("FAIL midrst_outputs: busy=%b done=%b req=%b addr=%0h data=%0h ds=%0d v=%b expected all 0",
               status_busy_o, event_done_o, mem_req_o, mem_addr_o, stream_data_o,
               stream_datasize_o, stream_valid_o);
    end
    rst_i = 1'b0;
    clear_logs();
    repeat (8) tick();
    tests++;
    if (valid_seen !== 1'b0 || busy_seen !== 1'b0 || done_cnt != 0) begin
      fails++; $display("FAIL midrst_stale: got valid_seen=%b busy_seen=%b done=%0d expected 0/0/0",
                        valid_seen, busy_seen, done_cnt);
    end
    clear_logs();
    start_xfer(18'h000, 2'b01, 1'b0, 16'd2, 16'd0, 16'd0);
    wait_done(100);
    tests++;
    if (cap_data.size() != 2 || cap_data[0] !== 32'h0000 || cap_data[1] !== 32'hC0DE ||
        sof_bits() !== 16'h0001 || eof_bits() !== 16'h0002) begin
      fails++; $display("FAIL midrst_rerun: got n=%0d sof=%0h eof=%0h expected 2 halves 0000,c0de sof=1 eof=2",
                        cap_data.size(), sof_bits(), eof_bits());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 + 32'(i);
    test_reset();
    test_linear_byte();
    test_half();
    test_2d_word();
    test_backpressure();
    test_gnt_wait();
    test_empty();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/udma_filter_stream_src.md
Name: udma_filter_stream_src

Overview:
- Memory-reading stream source that feeds operand ports of the filter arithmetic unit.
- Fetches elements from L2 over a req/gnt/rvalid port and extracts 8/16/32-bit elements.
- Emits them as a valid/ready stream with datasize, sof and eof qualifiers.
- One instance per operand channel (A, B) inside the filter datapath.

Parameters:
DATA_WIDTH, 32, stream data width (element right-aligned)
ADDR_WIDTH, 18, L2 byte-address width
TRANS_SIZE, 16, width of length/stride counters
FIFO_DEPTH, 4, return-data buffer depth = max requests in flight (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cmd_start_i  in  1  start pulse; sampled only in IDLE
cfg_start_addr_i  in  ADDR_WIDTH  byte start address
cfg_datasize_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
cfg_mode_i  in  1  0 linear, 1 2D
cfg_len0_i  in  TRANS_SIZE  elements per row (linear: total elements)
cfg_len1_i  in  TRANS_SIZE  row count (2D only)
cfg_stride_i  in  TRANS_SIZE  bytes between row start addresses (2D only)
status_busy_o  out  1  transfer in progress
event_done_o  out  1  one-cycle completion pulse
mem_req_o  out  1  read request
mem_addr_o  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
mem_gnt_i  in  1  request accepted
mem_rvalid_i  in  1  read data valid, in request order, >=1 cycle after gnt
mem_rdata_i  in  32  read data
stream_data_o  out  DATA_WIDTH  element, zero-extended
stream_datasize_o  out  2  copy of cfg_datasize_i latched at start
stream_valid_o  out  1  element available
stream_sof_o  out  1  first element of frame
stream_eof_o  out  1  last element of frame
stream_ready_i  in  1  consumer accepts

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters/FIFO cleared. rst_i mid-transfer aborts immediately; in-flight rvalids are dropped.
- cmd_start_i latches all cfg_* inputs. cfg changes afterwards have no effect. Start while busy is ignored.
- Empty transfer: if len0==0 or (2D and len1==0), no requests are issued. event_done_o pulses the cycle after start; busy stays 0.
- FSM: IDLE -> REQ on start -> DRAIN when last request granted -> IDLE after last stream handshake. busy=1 in REQ/DRAIN.
- Element address = base + row*stride + col*bytes(datasize), with bytes = 1/2/4. Computed incrementally, no multiplier; wraps modulo 2^ADDR_WIDTH.
- mem_addr_o = element address with [1:0] cleared.
- First mem_req_o is in the cycle after start. req/addr hold stable until gnt. A new address is presented in the cycle after gnt, with no bubble if credit allows.
- Credit: req only while (inflight + fifo_count) < FIFO_DEPTH. This guarantees rvalid always finds FIFO space; there is no response backpressure.
- Lane select: byte offset addr[1:0] travels with each request in a FIFO_DEPTH-deep tag queue.
  - byte: rdata[8*off+:8]; half: rdata[16*off[1]+:16]. Half addresses are 2-byte aligned; off[0] is ignored.
- sof/eof:
  - linear: sof on element 0, eof on element len0-1 (both on one element if len0==1).
  - 2D: sof/eof mark the first/last element of every row.
- Stream: the head of the FIFO drives the stream. Earliest valid is the cycle after rvalid. data/sof/eof stay stable while valid&!ready.
- Done: event_done_o pulses in the cycle after the final element's valid&ready. busy=0 in that cycle. A new start is accepted in the done cycle.
- Same-cycle rvalid push and stream pop are both honoured; occupancy is unchanged.

Decomposition:
- udma_filter_pkg holds:
  - datasize encodings (DS_BYTE/DS_HALF/DS_WORD)
  - mode encodings (SRC_LINEAR/SRC_2D)
  - FSM state enum (IDLE/REQ/DRAIN)
  - bytes-per-element function
- One sub-module: udma_filter_src_fifo, a synchronous FIFO of width DATA_WIDTH+2 (data, sof, eof) and depth FIFO_DEPTH with push/pop/count.
- The tag queue reuses udma_filter_src_fifo with width 2.

Test Plan:
1. Linear byte, base 0x100, len0=4, mem[0x100]=0x44332211, zero-latency gnt/ready -> four reqs at 0x100; stream 0x11,0x22,0x33,0x44; sof on the 1st element, eof on the 4th; one done pulse.
2. Half, base 0x102, len0=3, mem[0x100]=0xBBBBAAAA, mem[0x104]=0xDDDDCCCC -> addrs 0x100,0x104,0x104; data 0xBBBB,0xCCCC,0xDDDD.
3. 2D word, base 0x200, len0=2, len1=2, stride=0x10 -> addrs 0x200,0x204,0x210,0x214; sof at elements 0,2; eof at elements 1,3.
4. FIFO_DEPTH=4, len0=16, stream_ready_i=0 for 30 cycles -> exactly 4 grants, then req low; after release all 16 elements arrive in order; done pulse once.
5. gnt withheld 3 cycles per request plus random rvalid latency -> mem_addr_o stable while req&!gnt; data order matches addresses.
6. len0=0 -> no req, done the cycle after start. rst_i asserted mid-transfer -> next cycle all outputs 0; a new start then runs correctly.
